// File: rtl/bcd_7seg_scan_driver.sv
// Two-digit BCD to multiplexed 7-segment scan driver with tear-free frame commit.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit without changing scan timing.
module bcd_7seg_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_tens,
    input  logic [3:0] in_ones,
    input  logic       in_valid,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       frame_done,
    output logic       pending
);

    localparam int MAXD = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    POL      = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0]    SEG_OFF  = POL;

    typedef enum logic [1:0] {
        SHOW_ONES,
        GAP_A,
        SHOW_TENS,
        GAP_B
    } state_t;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] raw;
        case (d)
            4'd0:    raw = 7'h3F;
            4'd1:    raw = 7'h06;
            4'd2:    raw = 7'h5B;
            4'd3:    raw = 7'h4F;
            4'd4:    raw = 7'h66;
            4'd5:    raw = 7'h6D;
            4'd6:    raw = 7'h7D;
            4'd7:    raw = 7'h07;
            4'd8:    raw = 7'h7F;
            4'd9:    raw = 7'h6F;
            default: raw = 7'h79;
        endcase
        return raw ^ POL;
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_shadow_tens;
    logic [3:0]    r_shadow_ones;
    logic [3:0]    r_disp_tens;
    logic [3:0]    r_disp_ones;
    logic          r_pending;
    logic          r_frame_done;
    logic [1:0]    r_dig_en;
    logic [6:0]    r_seg;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_last;
    logic          w_commit;
    logic [3:0]    w_shadow_tens_nxt;
    logic [3:0]    w_shadow_ones_nxt;
    logic [3:0]    w_disp_tens_nxt;
    logic [3:0]    w_disp_ones_nxt;
    logic          w_pending_nxt;
    logic          w_frame_done_nxt;
    logic [1:0]    w_dig_en_nxt;
    logic [6:0]    w_seg_nxt;
    logic [6:0]    w_tens_seg;

    always_comb begin
        w_last      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        unique case (r_state)
            SHOW_ONES: begin
                w_last = (r_cnt == REF_LAST);
                if (w_last) w_state_nxt = GAP_A;
            end
            GAP_A: begin
                w_last = (r_cnt == BLK_LAST);
                if (w_last) w_state_nxt = SHOW_TENS;
            end
            SHOW_TENS: begin
                w_last = (r_cnt == REF_LAST);
                if (w_last) w_state_nxt = GAP_B;
            end
            GAP_B: begin
                w_last = (r_cnt == BLK_LAST);
                if (w_last) w_state_nxt = SHOW_ONES;
            end
        endcase
        if (w_last) w_cnt_nxt = '0;
    end

    // A strobe on the commit edge bypasses the shadow straight into the display.
    always_comb begin
        w_commit          = w_last && (r_state == GAP_B);
        w_shadow_tens_nxt = in_valid ? in_tens : r_shadow_tens;
        w_shadow_ones_nxt = in_valid ? in_ones : r_shadow_ones;
        w_disp_tens_nxt   = w_commit ? w_shadow_tens_nxt : r_disp_tens;
        w_disp_ones_nxt   = w_commit ? w_shadow_ones_nxt : r_disp_ones;
        w_pending_nxt     = w_commit ? 1'b0 : (r_pending | in_valid);
        w_frame_done_nxt  = (w_state_nxt == GAP_B) && (w_cnt_nxt == BLK_LAST);
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign w_tens_seg = (w_disp_tens_nxt == 4'd0) ? SEG_OFF : enc(w_disp_tens_nxt);
`else
    assign w_tens_seg = enc(w_disp_tens_nxt);
`endif

    always_comb begin
        w_dig_en_nxt = 2'b00;
        w_seg_nxt    = SEG_OFF;
        unique case (w_state_nxt)
            SHOW_ONES: begin
                w_dig_en_nxt = 2'b01;
                w_seg_nxt    = enc(w_disp_ones_nxt);
            end
            SHOW_TENS: begin
                w_dig_en_nxt = 2'b10;
                w_seg_nxt    = w_tens_seg;
            end
            GAP_A, GAP_B: begin
                w_dig_en_nxt = 2'b00;
                w_seg_nxt    = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= GAP_B;
            r_cnt         <= '0;
            r_shadow_tens <= 4'd0;
            r_shadow_ones <= 4'd0;
            r_disp_tens   <= 4'd0;
            r_disp_ones   <= 4'd0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_dig_en      <= 2'b00;
            r_seg         <= SEG_OFF;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shadow_tens <= w_shadow_tens_nxt;
            r_shadow_ones <= w_shadow_ones_nxt;
            r_disp_tens   <= w_disp_tens_nxt;
            r_disp_ones   <= w_disp_ones_nxt;
            r_pending     <= w_pending_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_dig_en      <= w_dig_en_nxt;
            r_seg         <= w_seg_nxt;
        end
    end

    assign seg        = r_seg;
    assign dig_en     = r_dig_en;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed bench for bcd_7seg_scan_driver, REFRESH_DIV=4, BLANK_CYCLES=2.
// Frame period is 12 cycles; cycle 0 is the first cycle after reset release.
module tb_bcd_7seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] in_tens;
    logic [3:0] in_ones;
    logic       in_valid;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       frame_done;
    logic       pending;

    int vectors;
    int miscompares;
    int cyc;
    logic [6:0] exp_ones;
    logic [6:0] exp_tens;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS0 = 7'h00;
`else
    localparam logic [6:0] TENS0 = 7'h3F;
`endif

    bcd_7seg_scan_driver #(
        .REFRESH_DIV   (4),
        .BLANK_CYCLES  (2),
        .SEG_ACTIVE_LOW(0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_tens   (in_tens),
        .in_ones   (in_ones),
        .in_valid  (in_valid),
        .seg       (seg),
        .dig_en    (dig_en),
        .frame_done(frame_done),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle_check(input string tag);
        int         ph;
        logic [1:0] ed;
        logic [6:0] es;
        logic       ef;
        ph = cyc % 12;
        ed = 2'b00;
        es = 7'h00;
        ef = (ph == 1);
        if (ph >= 2 && ph <= 5) begin
            ed = 2'b01;
            es = exp_ones;
        end else if (ph >= 8 && ph <= 11) begin
            ed = 2'b10;
            es = exp_tens;
        end
        check({tag, "_dig"}, 16'(dig_en), 16'(ed));
        check({tag, "_seg"}, 16'(seg), 16'(es));
        check({tag, "_fd"}, 16'(frame_done), 16'(ef));
        tick();
    endtask

    task automatic run_until(input string tag, input int target);
        while (cyc < target) cycle_check(tag);
    endtask

    task automatic strobe(input string tag, input logic [3:0] t, input logic [3:0] o);
        in_valid = 1'b1;
        in_tens  = t;
        in_ones  = o;
        cycle_check(tag);
        in_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_tens     = 4'd0;
        in_ones     = 4'd0;
        exp_ones    = 7'h3F;
        exp_tens    = TENS0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", 16'(seg), 16'h00);
        check("rst_dig", 16'(dig_en), 16'h0);
        check("rst_fd", 16'(frame_done), 16'h0);
        check("rst_pend", 16'(pending), 16'h0);
        rst = 1'b0;
        cyc = 0;

        run_until("s1", 14);

        run_until("s2a", 20);
        strobe("s2_stb", 4'd1, 4'd7);
        check("s2_pend_set", 16'(pending), 16'h1);
        run_until("s2b", 25);
        check("s2_pend_hold", 16'(pending), 16'h1);
        cycle_check("s2b");
        exp_ones = 7'h07;
        exp_tens = 7'h06;
        check("s2_pend_clr", 16'(pending), 16'h0);
        run_until("s2c", 40);

        strobe("s3_stb1", 4'd2, 4'd3);
        run_until("s3a", 44);
        strobe("s3_stb2", 4'd4, 4'd5);
        check("s3_pend", 16'(pending), 16'h1);
        run_until("s3b", 50);
        exp_ones = 7'h6D;
        exp_tens = 7'h66;
        check("s3_pend_clr", 16'(pending), 16'h0);
        run_until("s3c", 61);

        check("s4_pend_pre", 16'(pending), 16'h0);
        strobe("s4_stb", 4'd9, 4'd9);
        exp_ones = 7'h6F;
        exp_tens = 7'h6F;
        check("s4_pend", 16'(pending), 16'h0);
        run_until("s4", 76);

        strobe("s5_stb", 4'd0, 4'd12);
        run_until("s5a", 86);
        exp_ones = 7'h79;
        exp_tens = TENS0;
        run_until("s5b", 98);

        strobe("s6_stb", 4'd2, 4'd3);
        check("s6_pend_pre", 16'(pending), 16'h1);
        check("s6_dig_pre", 16'(dig_en), 16'h1);
        rst = 1'b1;
        #1;
        check("s6_rst_dig", 16'(dig_en), 16'h0);
        check("s6_rst_seg", 16'(seg), 16'h00);
        check("s6_rst_pend", 16'(pending), 16'h0);
        check("s6_rst_fd", 16'(frame_done), 16'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc      = 0;
        exp_ones = 7'h3F;
        exp_tens = TENS0;
        run_until("s6", 14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
